// File: rtl/ring_pkg.sv
// Shared defaults and FSM encoding for the L1A ring writer.
package ring_pkg;

  localparam int unsigned RING_AW_DEFAULT    = 10;
  localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

  // Writer FSM state; encoding 3 is unused and recovers to StIdle
  typedef logic [1:0] wr_state_t;

  localparam wr_state_t StIdle = 2'd0;
  localparam wr_state_t StFill = 2'd1;
  localparam wr_state_t StRun  = 2'd2;

endpackage

// File: rtl/l1a_addr_fifo.sv
// Pending-L1A start-address FIFO. The head entry is presented on data, reading
// as zero while empty. A push into a full FIFO is accepted when a pop frees a
// slot in the same cycle. flush empties it synchronously.
module l1a_addr_fifo #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          flush,
  input  logic          push,
  input  logic [AW-1:0] wdata,
  input  logic          pop,
  output logic [AW-1:0] data,
  output logic          empty,
  output logic          full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data    = empty ? '0 : mem[rd_ptr_q];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pointer and occupancy bookkeeping
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage; contents are only observed while the FIFO is non-empty
  always_ff @(posedge CLK) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/ring_l1a_writer.sv
// ADC ring-buffer writer with pending-L1A start-address tracking.
// Optional build macro: RING_DROP_CNT_EN enables the saturating DROP_CNT
// counter; when undefined DROP_CNT is tied to zero.
module ring_l1a_writer
  import ring_pkg::*;
#(
  parameter int unsigned RING_AW    = RING_AW_DEFAULT,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               ENABLE,
  input  logic               SAMP_STB,
  input  logic               L1A,
  input  logic [RING_AW-1:0] L1A_DELAY,
  input  logic               L1A_POP,
  input  logic               RD_SAMP,
  output logic               WE,
  output logic [RING_AW-1:0] WR_ADDR,
  output logic [RING_AW-1:0] L1A_ADDR,
  output logic               L1A_BUF_MT,
  output logic               L1A_BUF_FULL,
  output logic               RING_AMT,
  output logic               L1A_DROP,
  output logic [1:0]         WR_STATE,
  output logic [7:0]         DROP_CNT
);

  wr_state_t          state_q, state_d;
  logic [RING_AW-1:0] wp_q, wp_d;
  logic [RING_AW:0]   fill_q, fill_d;
  logic [RING_AW-1:0] cons_q, cons_d;
  logic               we_q, amt_q, amt_d, drop_q, drop_d;
  logic [RING_AW-1:0] wr_addr_q;
  logic               writing, l1a_ok, l1a_drop;
  logic               fifo_empty, fifo_full;
  logic [RING_AW-1:0] fifo_data;

  assign writing  = ENABLE && SAMP_STB && (state_q == StFill || state_q == StRun);
  // Full FIFO still accepts when the reader pops in the same cycle
  assign l1a_ok   = ENABLE && L1A && (state_q == StRun) && (!fifo_full || L1A_POP);
  assign l1a_drop = ENABLE && L1A && !l1a_ok;

  l1a_addr_fifo #(
    .AW   (RING_AW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK  (CLK),
    .RST  (RST),
    .flush(!ENABLE),
    .push (l1a_ok),
    .wdata(wp_q - L1A_DELAY),
    .pop  (ENABLE && L1A_POP),
    .data (fifo_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  // FSM, write pointer and fill count next-state
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    fill_d  = fill_q;
    if (!ENABLE) begin
      state_d = StIdle;
      wp_d    = '0;
      fill_d  = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StFill;
          fill_d  = '0;
        end
        StFill: begin
          if (SAMP_STB) begin
            wp_d   = wp_q + RING_AW'(1);
            fill_d = fill_q + (RING_AW+1)'(1);
            // This strobe brings the count to L1A_DELAY+1
            if (fill_q == {1'b0, L1A_DELAY}) state_d = StRun;
          end
        end
        StRun: begin
          if (SAMP_STB) wp_d = wp_q + RING_AW'(1);
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Consumed-sample count, drop flag and ring-almost-empty next-state
  always_comb begin
    cons_d = cons_q;
    if (!ENABLE || (L1A_POP && !fifo_empty)) begin
      cons_d = '0;
    end else if (RD_SAMP && !fifo_empty && (cons_q != '1)) begin
      cons_d = cons_q + RING_AW'(1);
    end
    drop_d = ENABLE && (drop_q || l1a_drop);
    amt_d  = !ENABLE || fifo_empty || ((wp_q - fifo_data) <= cons_q);
  end

  // State registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      wp_q      <= '0;
      fill_q    <= '0;
      cons_q    <= '0;
      we_q      <= 1'b0;
      wr_addr_q <= '0;
      amt_q     <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      fill_q  <= fill_d;
      cons_q  <= cons_d;
      we_q    <= writing;
      if (writing) wr_addr_q <= wp_q;
      amt_q   <= amt_d;
      drop_q  <= drop_d;
    end
  end

`ifdef RING_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  // Saturating dropped-L1A counter, cleared alongside L1A_DROP
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drop_cnt_q <= 8'd0;
    end else if (!ENABLE) begin
      drop_cnt_q <= 8'd0;
    end else if (l1a_drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign DROP_CNT = drop_cnt_q;
`else
  assign DROP_CNT = 8'd0;
`endif

  assign WE           = we_q;
  assign WR_ADDR      = wr_addr_q;
  assign L1A_ADDR     = fifo_data;
  assign L1A_BUF_MT   = fifo_empty;
  assign L1A_BUF_FULL = fifo_full;
  assign RING_AMT     = amt_q;
  assign L1A_DROP     = drop_q;
  assign WR_STATE     = state_q;

endmodule

// File: tb/tb_ring_l1a_writer.sv
// Directed self-checking bench for ring_l1a_writer with write-address and
// start-address scoreboards.
module tb_ring_l1a_writer;

  logic       CLK = 1'b0;
  logic       RST, ENABLE, SAMP_STB, L1A, L1A_POP, RD_SAMP;
  logic [9:0] L1A_DELAY;
  logic       WE, L1A_BUF_MT, L1A_BUF_FULL, RING_AMT, L1A_DROP;
  logic [9:0] WR_ADDR, L1A_ADDR;
  logic [1:0] WR_STATE;
  logic [7:0] DROP_CNT;

`ifdef RING_DROP_CNT_EN
  localparam int DropCntOn = 1;
`else
  localparam int DropCntOn = 0;
`endif

  int n_cmp = 0;
  int n_mis = 0;
  int wr_q[$];
  int l1a_q[$];
  int m_wp;
  int dly;

  ring_l1a_writer dut (
    .CLK         (CLK),
    .RST         (RST),
    .ENABLE      (ENABLE),
    .SAMP_STB    (SAMP_STB),
    .L1A         (L1A),
    .L1A_DELAY   (L1A_DELAY),
    .L1A_POP     (L1A_POP),
    .RD_SAMP     (RD_SAMP),
    .WE          (WE),
    .WR_ADDR     (WR_ADDR),
    .L1A_ADDR    (L1A_ADDR),
    .L1A_BUF_MT  (L1A_BUF_MT),
    .L1A_BUF_FULL(L1A_BUF_FULL),
    .RING_AMT    (RING_AMT),
    .L1A_DROP    (L1A_DROP),
    .WR_STATE    (WR_STATE),
    .DROP_CNT    (DROP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    cyc();
    cyc();
  endtask

  // One sample strobe while the writer is in FILL or RUN
  task automatic strobe();
    SAMP_STB = 1'b1;
    wr_q.push_back(m_wp);
    m_wp = (m_wp + 1) % 1024;
    cyc();
    SAMP_STB = 1'b0;
  endtask

  // Scoreboard: every WE must match the oldest expected write address
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      if (wr_q.size() == 0) check("we_spurious", WE, 0);
      else check("wr_addr", WR_ADDR, wr_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; ENABLE = 1'b0; SAMP_STB = 1'b0; L1A = 1'b0;
    L1A_POP = 1'b0; RD_SAMP = 1'b0; L1A_DELAY = 10'd4;
    dly = 4; m_wp = 0;
    cyc(); cyc();
    check("rst_state", WR_STATE, 0);
    check("rst_we", WE, 0);
    check("rst_wr_addr", WR_ADDR, 0);
    check("rst_mt", L1A_BUF_MT, 1);
    check("rst_full", L1A_BUF_FULL, 0);
    check("rst_amt", RING_AMT, 1);
    check("rst_drop", L1A_DROP, 0);
    check("rst_drop_cnt", DROP_CNT, 0);
    check("rst_l1a_addr", L1A_ADDR, 0);

    // Fill with delay 4: RUN after the fifth strobe, writes 0..4
    RST = 1'b0; ENABLE = 1'b1;
    cyc();
    check("state_fill", WR_STATE, 1);
    repeat (4) strobe();
    check("state_fill_4", WR_STATE, 1);
    strobe();
    check("state_run", WR_STATE, 2);

    // L1A at wp=20 -> start address 16
    repeat (15) strobe();
    L1A = 1'b1;
    l1a_q.push_back((m_wp - dly) & 1023);
    cyc();
    L1A = 1'b0;
    check("mt_after_l1a", L1A_BUF_MT, 0);
    check("l1a_addr_16", L1A_ADDR, l1a_q[0]);
    settle();
    check("amt_fresh", RING_AMT, 0);

    // Ring-almost-empty: written span 4, consumed 3 then 4, then one more sample
    RD_SAMP = 1'b1;
    repeat (3) cyc();
    RD_SAMP = 1'b0;
    settle();
    check("amt_cons3", RING_AMT, 0);
    RD_SAMP = 1'b1;
    cyc();
    RD_SAMP = 1'b0;
    settle();
    check("amt_cons4", RING_AMT, 1);
    strobe();
    settle();
    check("amt_new_samp", RING_AMT, 0);

    // Pop the head, then a pop while empty
    L1A_POP = 1'b1;
    cyc();
    void'(l1a_q.pop_front());
    check("mt_after_pop", L1A_BUF_MT, 1);
    cyc();
    L1A_POP = 1'b0;
    check("mt_pop_empty", L1A_BUF_MT, 1);
    settle();
    check("amt_empty", RING_AMT, 1);

    // Eight L1As each with a same-cycle strobe: address uses the pre-strobe wp
    for (int i = 0; i < 8; i++) begin
      L1A = 1'b1; SAMP_STB = 1'b1;
      l1a_q.push_back((m_wp - dly) & 1023);
      wr_q.push_back(m_wp);
      m_wp = (m_wp + 1) % 1024;
      cyc();
      if (i == 6) check("not_full_7", L1A_BUF_FULL, 0);
    end
    L1A = 1'b0; SAMP_STB = 1'b0;
    check("full_8", L1A_BUF_FULL, 1);
    check("head_full", L1A_ADDR, l1a_q[0]);

    // Full FIFO with same-cycle push and pop: accepted, still full, no drop
    L1A = 1'b1; L1A_POP = 1'b1;
    void'(l1a_q.pop_front());
    l1a_q.push_back((m_wp - dly) & 1023);
    cyc();
    L1A = 1'b0; L1A_POP = 1'b0;
    check("full_pushpop", L1A_BUF_FULL, 1);
    check("drop_pushpop", L1A_DROP, 0);
    check("head_pushpop", L1A_ADDR, l1a_q[0]);

    // Ninth L1A without pop is dropped
    L1A = 1'b1;
    cyc();
    L1A = 1'b0;
    check("drop_9th", L1A_DROP, 1);
    check("drop_cnt_9th", DROP_CNT, DropCntOn);
    check("full_9th", L1A_BUF_FULL, 1);
    check("head_9th", L1A_ADDR, l1a_q[0]);

    // Drain all entries in order
    for (int i = 0; i < 8; i++) begin
      check("drain_head", L1A_ADDR, l1a_q[0]);
      L1A_POP = 1'b1;
      cyc();
      L1A_POP = 1'b0;
      void'(l1a_q.pop_front());
    end
    check("mt_drained", L1A_BUF_MT, 1);
    check("drop_sticky", L1A_DROP, 1);

    // ENABLE low flushes and clears the drop flag
    ENABLE = 1'b0;
    cyc();
    check("dis_state", WR_STATE, 0);
    check("dis_drop", L1A_DROP, 0);
    check("dis_drop_cnt", DROP_CNT, 0);
    check("dis_mt", L1A_BUF_MT, 1);

    // New run with delay 5; L1A during FILL is dropped
    L1A_DELAY = 10'd5; dly = 5; m_wp = 0;
    ENABLE = 1'b1;
    cyc();
    L1A = 1'b1;
    cyc();
    L1A = 1'b0;
    check("drop_fill", L1A_DROP, 1);
    check("drop_cnt_fill", DROP_CNT, DropCntOn);
    check("mt_fill_l1a", L1A_BUF_MT, 1);

    // Wrap wp past 1023 to 2, then L1A -> 1021
    repeat (1026) strobe();
    check("state_run2", WR_STATE, 2);
    L1A = 1'b1;
    l1a_q.push_back((m_wp - dly) & 1023);
    cyc();
    L1A = 1'b0;
    check("l1a_addr_wrap", L1A_ADDR, l1a_q[0]);
    check("mt_wrap", L1A_BUF_MT, 0);

    // Reset mid-run discards pending events; no WE until a strobe in FILL
    RST = 1'b1;
    #1;
    check("mid_rst_mt", L1A_BUF_MT, 1);
    check("mid_rst_state", WR_STATE, 0);
    check("mid_rst_we", WE, 0);
    l1a_q.delete();
    cyc();
    RST = 1'b0; m_wp = 0;
    cyc();
    check("post_rst_fill", WR_STATE, 1);
    repeat (3) cyc();
    strobe();
    settle();
    check("wr_pending", wr_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
